out_sender: RTL and testbench



---
 rtl/out_sender.sv | 145 ++++++++++++++
 tb/tb_out_sender.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/out_sender.sv
// UART transmit side of the calculator link: serialises the captured result
// buffer as 8N1 frames, LSB first, skipping null bytes and appending EOL_CHAR.
module out_sender #(
  parameter int          CLKS_PER_BIT = 10417,
  parameter int          NUM_CHARS    = 15,
  parameter logic [7:0]  EOL_CHAR     = 8'h0d
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   out_en,
  input  logic [8*NUM_CHARS-1:0] out_q,
  output logic                   tx,
  output logic                   busy,
  output logic                   sent
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_EOL   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  logic [2:0]             state;
  logic [IDX_W-1:0]       idx;
  logic [2:0]             bit_cnt;
  logic [CNT_W-1:0]       baud_cnt;
  logic                   eol_flag;
  logic [8*NUM_CHARS-1:0] buf_q;
  logic [7:0]             shift;
  logic [7:0]             byte_sel;
  logic                   tx_nxt;
  logic                   baud_end;

  assign baud_end = (baud_cnt == BAUD_MAX);

  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < NUM_CHARS; i++)
      if (idx == IDX_W'(i)) byte_sel = buf_q[8*(NUM_CHARS-1-i) +: 8];
  end

  // Line level is a function of the current state; registering it keeps tx glitch-free.
  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shift[bit_cnt];
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      eol_flag <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      sent     <= 1'b0;
    end else begin
      tx   <= tx_nxt;
      sent <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (out_en) begin
            idx      <= '0;
            eol_flag <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          baud_cnt <= '0;
          if (byte_sel != 8'h00) state <= ST_START;
          else if (idx == LAST_IDX) state <= ST_EOL;
          else idx <= idx + 1'b1;
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) state <= ST_STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (eol_flag) begin
              sent  <= 1'b1;
              state <= ST_DONE;
            end else if (idx == LAST_IDX) begin
              state <= ST_EOL;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_SCAN;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_EOL: begin
          eol_flag <= 1'b1;
          baud_cnt <= '0;
          state    <= ST_START;
        end
        ST_DONE: begin
          // Hold until control drops its request so one request yields one message.
          if (!out_en) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Message and character storage carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && out_en) buf_q <= out_q;
    if (state == ST_SCAN && byte_sel != 8'h00) shift <= byte_sel;
    else if (state == ST_EOL) shift <= EOL_CHAR;
  end

endmodule

// File: tb/tb_out_sender.sv
// Randomised and directed checks of out_sender against a frame-level model:
// expected byte list, frame shape and message timing derived from the slot contents.
module tb_out_sender;

  localparam int CPB = 4;
  localparam int NC  = 15;
  localparam int NB  = 8 * NC;

  logic          clk = 1'b0;
  logic          rst;
  logic          out_en;
  logic [NB-1:0] out_q;
  logic          tx;
  logic          busy;
  logic          sent;

  int n_chk  = 0;
  int n_fail = 0;

  out_sender #(.CLKS_PER_BIT(CPB), .NUM_CHARS(NC), .EOL_CHAR(8'h0d)) dut (
    .clk   (clk),
    .rst   (rst),
    .out_en(out_en),
    .out_q (out_q),
    .tx    (tx),
    .busy  (busy),
    .sent  (sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; the next posedge captures the message.
  task automatic run_msg(input logic [NB-1:0] data, input int drop_at, input bit filler,
                         input int hold, input string tag);
    logic        txs[$];
    byte unsigned expq[$];
    byte unsigned gotq[$];
    byte unsigned b;
    int lead, nn, sent_at, busy_low, first_fall, frame_err, c, n;
    int post_bad;

    lead = -1;
    for (int i = 0; i < NC; i++) begin
      b = data[8*(NC-1-i) +: 8];
      if (b != 8'h00) begin
        expq.push_back(b);
        if (lead < 0) lead = i;
      end
    end
    nn = expq.size();
    expq.push_back(8'h0d);
    if (lead < 0) lead = NC;

    out_q  = data;
    out_en = 1'b1;
    @(posedge clk);
    sent_at  = -1;
    busy_low = 0;
    for (int k = 0; k < 2000 && sent_at < 0; k++) begin
      @(negedge clk);
      if (k == 0 && filler) out_q = {NC{8'h39}};
      if (k == drop_at) out_en = 1'b0;
      txs.push_back(tx);
      if (!busy) busy_low++;
      if (sent) sent_at = k;
    end

    chk({tag, ".sent_at"}, sent_at, NC + 10*CPB*nn + 1 + 10*CPB);
    chk({tag, ".busy_in_msg"}, busy_low, 0);

    first_fall = -1;
    frame_err  = 0;
    c = 1;
    while (c < txs.size()) begin
      if (txs[c] == 1'b0 && txs[c-1] == 1'b1) begin
        if (first_fall < 0) first_fall = c;
        if (c + 10*CPB - 1 >= txs.size()) begin
          frame_err++;
          break;
        end
        for (int j = 0; j < 10; j++)
          for (int m = 1; m < CPB; m++)
            if (txs[c+CPB*j+m] != txs[c+CPB*j]) frame_err++;
        if (txs[c+9*CPB] != 1'b1) frame_err++;
        b = 8'h00;
        for (int j = 0; j < 8; j++) b[j] = txs[c+CPB*(j+1)];
        gotq.push_back(b);
        c += 10*CPB;
      end else begin
        c++;
      end
    end

    chk({tag, ".first_fall"}, first_fall, lead + 2);
    chk({tag, ".frame_err"}, frame_err, 0);
    chk({tag, ".nframes"}, gotq.size(), expq.size());
    n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.byte%0d", tag, i), int'(gotq[i]), int'(expq[i]));

    post_bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (sent || !tx || !busy) post_bad++;
    end
    if (hold > 0) chk({tag, ".done_hold"}, post_bad, 0);

    out_en = 1'b0;
    @(negedge clk);
    chk({tag, ".busy_release"}, int'(busy), 0);
    chk({tag, ".sent_once"}, int'(sent), 0);
    chk({tag, ".tx_idle"}, int'(tx), 1);
  endtask

  initial begin
    logic [NB-1:0] rdata;
    rst    = 1'b1;
    out_en = 1'b0;
    out_q  = '0;
    repeat (3) @(negedge clk);
    chk("rst.tx", int'(tx), 1);
    chk("rst.busy", int'(busy), 0);
    chk("rst.sent", int'(sent), 0);
    rst = 1'b0;
    @(negedge clk);

    run_msg({8'h31, 8'h32, {13{8'h00}}}, -1, 1'b0, 0, "t1");
    run_msg('0, -1, 1'b0, 0, "t2");
    run_msg({NC{8'h41}}, -1, 1'b0, 0, "t3");

    // Reset in DATA bit 3 of 0x31 (line low there), then restart from slot 0.
    @(negedge clk);
    out_q  = {8'h31, 8'h32, {13{8'h00}}};
    out_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4.pre_rst_tx", int'(tx), 0);
    rst = 1'b1;
    #1;
    chk("t4.rst_tx", int'(tx), 1);
    chk("t4.rst_busy", int'(busy), 0);
    chk("t4.rst_sent", int'(sent), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_msg({8'h31, 8'h32, {13{8'h00}}}, -1, 1'b0, 0, "t4");

    @(negedge clk);
    run_msg({8'h00, 8'h35, 8'h0d, {12{8'h00}}}, -1, 1'b0, 100, "t5a");
    @(negedge clk);
    run_msg({8'h36, {14{8'h00}}}, -1, 1'b0, 0, "t5b");

    @(negedge clk);
    run_msg({8'h00, 8'h00, 8'h37, 8'h00, 8'h38, {10{8'h00}}}, -1, 1'b1, 0, "t6");

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NC; i++)
        rdata[8*i +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      @(negedge clk);
      run_msg(rdata, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(3, 200)),
              1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
